// File: rtl/pong_game_engine.sv
// Pong game-state engine: ball, paddles, scores and the serve/play/score sequence, stepped once per frame.
// Optional BALL_SPEEDUP_EN: ball speed register that grows by one on every paddle hit (saturating at 8).
module pong_game_engine #(
  parameter int unsigned CANVAS_TOP    = 50,
  parameter int unsigned CANVAS_BOTTOM = 450,
  parameter int unsigned CANVAS_LEFT   = 50,
  parameter int unsigned CANVAS_RIGHT  = 600,
  parameter int unsigned BALL_SIZE     = 10,
  parameter int unsigned PADDLE_OFFSET = 20,
  parameter int unsigned PADDLE_HEIGHT = 50,
  parameter int unsigned PADDLE_WIDTH  = 10,
  parameter int unsigned BALL_SPEED    = 2,
  parameter int unsigned PADDLE_SPEED  = 4,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned WIN_SCORE     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_v_sync,
  input  logic       start,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [9:0] paddle_left_pos,
  output logic [9:0] paddle_right_pos,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] game_state,
  output logic       point_left,
  output logic       point_right,
  output logic       winner
);

  localparam int unsigned CW         = 10;
  localparam int unsigned SW         = 4;
  localparam int unsigned CNT_W      = $clog2(SERVE_FRAMES);
  localparam int unsigned BALL_X0    = (CANVAS_LEFT + CANVAS_RIGHT) / 2 - BALL_SIZE / 2;
  localparam int unsigned BALL_Y0    = (CANVAS_TOP + CANVAS_BOTTOM) / 2 - BALL_SIZE / 2;
  localparam int unsigned PADDLE_Y0  = (CANVAS_TOP + CANVAS_BOTTOM) / 2 - PADDLE_HEIGHT / 2;
  localparam int unsigned PAD_MIN    = CANVAS_TOP + 1;
  localparam int unsigned PAD_MAX    = CANVAS_BOTTOM - PADDLE_HEIGHT;
  localparam int unsigned BALL_Y_MIN = CANVAS_TOP + 1;
  localparam int unsigned BALL_Y_MAX = CANVAS_BOTTOM - BALL_SIZE;
  localparam int unsigned LEFT_FACE  = CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH;
  localparam int unsigned RIGHT_FACE = CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    SCORED   = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t           state;
  logic             v_prev;
  logic             dir_x_left;
  logic             dir_y_up;
  logic [CNT_W-1:0] serve_cnt;
  logic [CW-1:0]    spd;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] speed;
  assign spd = CW'(speed);
`else
  assign spd = CW'(BALL_SPEED);
`endif

  logic          tick;
  logic          left_overlap, right_overlap;
  logic          left_hit, right_hit, left_miss, right_miss;
  logic [CW-1:0] y_next;
  logic          y_next_up;

  assign tick       = vga_v_sync & ~v_prev;
  assign game_state = state;

  // Paddle/ball overlap and face-crossing tests, all on pre-update positions
  assign left_overlap  = (ball_pos_y + CW'(BALL_SIZE) > paddle_left_pos) &&
                         (ball_pos_y < paddle_left_pos + CW'(PADDLE_HEIGHT));
  assign right_overlap = (ball_pos_y + CW'(BALL_SIZE) > paddle_right_pos) &&
                         (ball_pos_y < paddle_right_pos + CW'(PADDLE_HEIGHT));
  assign left_hit   = dir_x_left && (ball_pos_x >= CW'(LEFT_FACE)) &&
                      (ball_pos_x <= CW'(LEFT_FACE) + spd) && left_overlap;
  assign right_hit  = !dir_x_left && (ball_pos_x + CW'(BALL_SIZE) <= CW'(RIGHT_FACE)) &&
                      (ball_pos_x + spd + CW'(BALL_SIZE) >= CW'(RIGHT_FACE)) && right_overlap;
  assign left_miss  = dir_x_left && (ball_pos_x <= CW'(CANVAS_LEFT) + spd);
  assign right_miss = !dir_x_left && (ball_pos_x + CW'(BALL_SIZE) + spd >= CW'(CANVAS_RIGHT));

  // Vertical step with wall bounce; compares arranged so nothing underflows
  always_comb begin
    y_next    = ball_pos_y;
    y_next_up = dir_y_up;
    if (!dir_y_up) begin
      if (ball_pos_y + spd >= CW'(BALL_Y_MAX)) begin
        y_next    = CW'(BALL_Y_MAX);
        y_next_up = 1'b1;
      end else begin
        y_next = ball_pos_y + spd;
      end
    end else if (ball_pos_y <= CW'(BALL_Y_MIN) + spd) begin
      y_next    = CW'(BALL_Y_MIN);
      y_next_up = 1'b0;
    end else begin
      y_next = ball_pos_y - spd;
    end
  end

  function automatic logic [CW-1:0] paddle_next(input logic [CW-1:0] pos,
                                                 input logic up, input logic dn);
    if (up && !dn)
      return (pos <= CW'(PAD_MIN + PADDLE_SPEED)) ? CW'(PAD_MIN) : pos - CW'(PADDLE_SPEED);
    if (dn && !up)
      return (pos + CW'(PADDLE_SPEED) >= CW'(PAD_MAX)) ? CW'(PAD_MAX) : pos + CW'(PADDLE_SPEED);
    return pos;
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    return (s == SW'(15)) ? SW'(15) : s + SW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      v_prev           <= 1'b0;
      ball_pos_x       <= CW'(BALL_X0);
      ball_pos_y       <= CW'(BALL_Y0);
      paddle_left_pos  <= CW'(PADDLE_Y0);
      paddle_right_pos <= CW'(PADDLE_Y0);
      score_left       <= '0;
      score_right      <= '0;
      dir_x_left       <= 1'b0;
      dir_y_up         <= 1'b0;
      serve_cnt        <= '0;
      point_left       <= 1'b0;
      point_right      <= 1'b0;
      winner           <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed            <= 4'(BALL_SPEED);
`endif
    end else begin
      v_prev      <= vga_v_sync;
      point_left  <= 1'b0;
      point_right <= 1'b0;
      if (tick) begin
        if (state != GAMEOVER) begin
          paddle_left_pos  <= paddle_next(paddle_left_pos, left_up, left_down);
          paddle_right_pos <= paddle_next(paddle_right_pos, right_up, right_down);
        end
        case (state)
          IDLE: begin
            ball_pos_x <= CW'(BALL_X0);
            ball_pos_y <= CW'(BALL_Y0);
            if (start) begin
              state     <= SERVE;
              serve_cnt <= '0;
`ifdef BALL_SPEEDUP_EN
              speed     <= 4'(BALL_SPEED);
`endif
            end
          end
          SERVE: begin
            ball_pos_x <= CW'(BALL_X0);
            ball_pos_y <= CW'(BALL_Y0);
            if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) state <= PLAY;
            else serve_cnt <= serve_cnt + CNT_W'(1);
          end
          PLAY: begin
            ball_pos_y <= y_next;
            dir_y_up   <= y_next_up;
            if (left_hit || right_hit) begin
              ball_pos_x <= left_hit ? CW'(LEFT_FACE) : CW'(RIGHT_FACE - BALL_SIZE);
              dir_x_left <= right_hit;
`ifdef BALL_SPEEDUP_EN
              if (speed != 4'd8) speed <= speed + 4'd1;
`endif
            end else if (left_miss) begin
              score_right <= sat_inc(score_right);
              point_right <= 1'b1;
              state       <= SCORED;
            end else if (right_miss) begin
              score_left <= sat_inc(score_left);
              point_left <= 1'b1;
              state      <= SCORED;
            end else begin
              ball_pos_x <= dir_x_left ? ball_pos_x - spd : ball_pos_x + spd;
            end
          end
          // dir_x still points at the side that missed, so it names the scorer
          SCORED: begin
            if ((dir_x_left ? score_right : score_left) == SW'(WIN_SCORE)) begin
              state  <= GAMEOVER;
              winner <= dir_x_left;
            end else begin
              ball_pos_x <= CW'(BALL_X0);
              ball_pos_y <= CW'(BALL_Y0);
              state      <= SERVE;
              serve_cnt  <= '0;
`ifdef BALL_SPEEDUP_EN
              speed      <= 4'(BALL_SPEED);
`endif
            end
          end
          GAMEOVER: begin
            if (start) begin
              score_left  <= '0;
              score_right <= '0;
              ball_pos_x  <= CW'(BALL_X0);
              ball_pos_y  <= CW'(BALL_Y0);
              state       <= SERVE;
              serve_cnt   <= '0;
`ifdef BALL_SPEEDUP_EN
              speed       <= 4'(BALL_SPEED);
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomised bench for pong_game_engine: a frame-level game model checked against the DUT every clock.
module tb_pong_game_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vga_v_sync = 1'b0;
  logic       start = 1'b0;
  logic       left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [9:0] ball_pos_x, ball_pos_y, paddle_left_pos, paddle_right_pos;
  logic [3:0] score_left, score_right;
  logic [2:0] game_state;
  logic       point_left, point_right, winner;

  pong_game_engine dut (
    .clk(clk), .reset(reset), .vga_v_sync(vga_v_sync), .start(start),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .paddle_left_pos(paddle_left_pos), .paddle_right_pos(paddle_right_pos),
    .score_left(score_left), .score_right(score_right), .game_state(game_state),
    .point_left(point_left), .point_right(point_right), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit active   = 0;

  // Game model: plain signed integers, directions as +1/-1
  int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_cnt, m_dx, m_dy, m_win, m_scorer;
  bit m_vprev, m_ptl, m_ptr;
  int hits = 0, misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp))
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int pad_move(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 51) ? 51 : p - 4;
    if (dn && !up) return (p + 4 > 400) ? 400 : p + 4;
    return p;
  endfunction

  task automatic centre();
    m_bx = 320;
    m_by = 245;
  endtask

  task automatic model_reset();
    centre();
    m_pl = 225; m_pr = 225; m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
    m_dx = 1; m_dy = 1; m_win = 0; m_scorer = 0; m_vprev = 0;
  endtask

  task automatic model_tick();
    int opl, opr, oy;
    opl = m_pl; opr = m_pr; oy = m_by;
    if (m_st != 4) begin
      m_pl = pad_move(m_pl, left_up, left_down);
      m_pr = pad_move(m_pr, right_up, right_down);
    end
    case (m_st)
      0: begin
        centre();
        if (start) begin m_st = 1; m_cnt = 0; end
      end
      1: begin
        centre();
        if (m_cnt == 59) m_st = 2;
        else m_cnt++;
      end
      2: begin
        if (m_dy > 0) begin
          if (oy + 2 >= 440) begin m_by = 440; m_dy = -1; end
          else m_by = oy + 2;
        end else begin
          if (oy - 2 <= 51) begin m_by = 51; m_dy = 1; end
          else m_by = oy - 2;
        end
        if (m_dx < 0) begin
          if (m_bx >= 80 && m_bx - 2 <= 80 && oy + 10 > opl && oy < opl + 50) begin
            m_bx = 80; m_dx = 1; hits++;
          end else if (m_bx - 2 <= 50) begin
            m_sr = (m_sr == 15) ? 15 : m_sr + 1; m_ptr = 1; m_st = 3; m_scorer = 1; misses++;
          end else m_bx = m_bx - 2;
        end else begin
          if (m_bx + 10 <= 570 && m_bx + 12 >= 570 && oy + 10 > opr && oy < opr + 50) begin
            m_bx = 560; m_dx = -1; hits++;
          end else if (m_bx + 12 >= 600) begin
            m_sl = (m_sl == 15) ? 15 : m_sl + 1; m_ptl = 1; m_st = 3; m_scorer = 0; misses++;
          end else m_bx = m_bx + 2;
        end
      end
      3: begin
        if ((m_scorer ? m_sr : m_sl) == 7) begin
          m_st = 4; m_win = m_scorer;
        end else begin
          centre();
          m_dx = m_scorer ? -1 : 1;
          m_st = 1; m_cnt = 0;
        end
      end
      default: begin
        if (start) begin
          m_sl = 0; m_sr = 0; centre(); m_st = 1; m_cnt = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    m_ptl = 0;
    m_ptr = 0;
    if (!reset) model_reset();
    else begin
      if (vga_v_sync && !m_vprev) model_tick();
      m_vprev = vga_v_sync;
    end
  end

  always @(negedge clk) begin
    if (active) begin
      chk("ball_x", 32'(ball_pos_x), m_bx);
      chk("ball_y", 32'(ball_pos_y), m_by);
      chk("paddle_left", 32'(paddle_left_pos), m_pl);
      chk("paddle_right", 32'(paddle_right_pos), m_pr);
      chk("score_left", 32'(score_left), m_sl);
      chk("score_right", 32'(score_right), m_sr);
      chk("game_state", 32'(game_state), m_st);
      chk("point_left", 32'(point_left), int'(m_ptl));
      chk("point_right", 32'(point_right), int'(m_ptr));
      if (m_st == 4) chk("winner", 32'(winner), m_win);
    end
  end

  task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    @(negedge clk);
    left_up = lu; left_down = ld; right_up = ru; right_down = rd; start = st;
    vga_v_sync = 1'b1;
    repeat (2) @(negedge clk);
    vga_v_sync = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  bit trk_l, trk_r;

  // Steer a paddle's centre toward the model ball's centre
  task automatic steer(input int pad, output bit up, output bit dn);
    up = (pad + 25 > m_by + 7);
    dn = (pad + 25 < m_by + 3);
  endtask

  task automatic random_frame(input bit allow_start);
    bit lu, ld, ru, rd, st;
    lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
    ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
    if (trk_l) steer(m_pl, lu, ld);
    if (trk_r) steer(m_pr, ru, rd);
    st = allow_start && (m_st != 4) && ($urandom_range(0, 7) == 0);
    frame(lu, ld, ru, rd, st);
  endtask

  task automatic random_play(input int n_frames, input bit stop_at_gameover, output bit reached);
    int last_hits, last_st;
    reached = 0;
    last_hits = hits;
    last_st = m_st;
    for (int f = 0; f < n_frames; f++) begin
      if (hits != last_hits || (m_st == 1 && last_st != 1)) begin
        trk_l = ($urandom_range(0, 99) < 35);
        trk_r = ($urandom_range(0, 99) < 35);
      end
      last_hits = hits;
      last_st = m_st;
      random_frame(!stop_at_gameover);
      if (stop_at_gameover && m_st == 4) begin
        reached = 1;
        break;
      end
    end
  endtask

  initial begin
    bit reached;
    trk_l = 0;
    trk_r = 0;
    @(negedge clk);
    active = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_ball_x", 32'(ball_pos_x), 320);
    chk("rst_ball_y", 32'(ball_pos_y), 245);
    chk("rst_paddle_left", 32'(paddle_left_pos), 225);
    chk("rst_paddle_right", 32'(paddle_right_pos), 225);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_scores", 32'({score_left, score_right}), 0);
    chk("rst_pulses", 32'({point_left, point_right}), 0);

    // Left paddle climbs to the top wall; right paddle with both buttons holds
    for (int t = 1; t <= 60; t++) begin
      frame(1, 0, 1, 1, 0);
      if (t == 1)  chk("pad_up_t1", 32'(paddle_left_pos), 221);
      if (t == 43) chk("pad_up_t43", 32'(paddle_left_pos), 53);
      if (t == 44) chk("pad_up_t44", 32'(paddle_left_pos), 51);
    end
    chk("pad_up_hold", 32'(paddle_left_pos), 51);
    chk("pad_both_hold", 32'(paddle_right_pos), 225);

    frame(0, 0, 0, 0, 1);
    chk("serve_entry", 32'(game_state), 1);
    for (int t = 1; t <= 59; t++) frame(0, 0, 0, 0, 0);
    chk("serve_hold_59", 32'(game_state), 1);
    frame(0, 0, 0, 0, 0);
    chk("play_entry", 32'(game_state), 2);
    chk("play_ball_still_x", 32'(ball_pos_x), 320);
    frame(0, 0, 0, 0, 0);
    chk("first_move_x", 32'(ball_pos_x), 322);
    chk("first_move_y", 32'(ball_pos_y), 247);

    random_play(8000, 1, reached);
    if (!reached) begin
      n_checks++;
      $display("FAIL gameover_timeout: model never reached game over (hits=%0d points=%0d)", hits, misses);
    end else begin
      chk("gameover_state", 32'(game_state), 4);
      chk("winner_has_7", 32'(winner ? score_right : score_left), 7);
      for (int t = 0; t < 10; t++) random_frame(0);
      chk("gameover_frozen", 32'(game_state), 4);
      frame(1, 0, 0, 1, 1);
      chk("restart_state", 32'(game_state), 1);
      chk("restart_scores", 32'({score_left, score_right}), 0);
      chk("restart_ball_x", 32'(ball_pos_x), 320);
      chk("restart_ball_y", 32'(ball_pos_y), 245);
    end

    random_play(600, 0, reached);

    // Reset in the middle of a frame with v_sync held high
    @(negedge clk);
    vga_v_sync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("midrst_state", 32'(game_state), 0);
    chk("midrst_ball", 32'({ball_pos_x, ball_pos_y}), (320 << 10) | 245);
    chk("midrst_paddles", 32'({paddle_left_pos, paddle_right_pos}), (225 << 10) | 225);
    chk("midrst_scores", 32'({score_left, score_right}), 0);
    reset = 1'b1;
    vga_v_sync = 1'b0;
    for (int t = 0; t < 5; t++) frame(0, 1, 1, 0, 0);
    chk("post_rst_pad_left", 32'(paddle_left_pos), 245);
    chk("post_rst_pad_right", 32'(paddle_right_pos), 205);

    @(negedge clk);
    active = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
